// File: rtl/cska_pkg.sv
// Shared constants for the multi-precision cska sequencer: byte width and FSM state encoding.
package cska_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        StIdle = ST_IDLE,
        StRun  = ST_RUN,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/cska_mp_seq_if.sv
// Command/result handshake bundle of the multi-precision sequencer.
interface cska_mp_seq_if #(
    parameter int unsigned NB = 4
) ();

    logic              in_valid;
    logic              in_ready;
    logic [8*NB-1:0]   op_a;
    logic [8*NB-1:0]   op_b;
    logic              op_cin;
    logic              op_sub;
    logic              out_valid;
    logic              out_ready;
    logic [8*NB-1:0]   res_sum;
    logic              res_cout;
    logic              res_ovf;
    logic              busy;

    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        input  in_ready, out_valid, res_sum, res_cout, res_ovf, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub, out_ready,
        output in_ready, out_valid, res_sum, res_cout, res_ovf, busy
    );

endinterface

// File: rtl/cska.sv
// 8-bit carry-skip adder: two 4-bit ripple blocks, each bypassed when all its bits propagate.
module cska
    import cska_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    localparam int unsigned BLK_W = 4;
    localparam int unsigned N_BLK = BYTE_W / BLK_W;

    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] g;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        logic c;
        logic c_blk;
        s     = '0;
        c_blk = cin;
        for (int blk = 0; blk < N_BLK; blk++) begin
            c = c_blk;
            for (int i = 0; i < BLK_W; i++) begin
                s[blk*BLK_W+i] = p[blk*BLK_W+i] ^ c;
                c = g[blk*BLK_W+i] | (p[blk*BLK_W+i] & c);
            end
            // A fully-propagating block passes its incoming carry straight through.
            c_blk = (&p[blk*BLK_W +: BLK_W]) ? c_blk : c;
        end
        cout = c_blk;
    end

endmodule

// File: rtl/cska_mp_seq.sv
// Multi-precision add/subtract sequencer: one byte per clock through a shared cska, LSB first,
// with the byte carry held in a register between steps.
module cska_mp_seq
    import cska_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    cska_mp_seq_if.slave  bus
);

    localparam int unsigned W    = BYTE_W * NB;
    localparam int unsigned IDXW = $clog2(NB);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

    state_e state_q, state_d;

    logic [W-1:0]      a_q, b_q, sum_q;
    logic              carry_q, cout_q, ovf_q;
    logic [IDXW-1:0]   idx_q;

    logic [BYTE_W-1:0] a_byte, b_byte, s_byte;
    logic              s_cout;
    logic              in_ready, out_valid, busy;
    logic              accept, last;

    assign a_byte = a_q[idx_q*BYTE_W +: BYTE_W];
    assign b_byte = b_q[idx_q*BYTE_W +: BYTE_W];
    assign accept = bus.in_valid & in_ready;
    assign last   = (idx_q == LAST_IDX);

    cska u_cska (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (carry_q),
        .s    (s_byte),
        .cout (s_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            // Subtraction is A + ~B + 1: invert B once here, seed the carry with 1.
            a_q     <= bus.op_a;
            b_q     <= bus.op_sub ? ~bus.op_b : bus.op_b;
            carry_q <= bus.op_sub ? 1'b1 : bus.op_cin;
            sum_q   <= '0;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            sum_q[idx_q*BYTE_W +: BYTE_W] <= s_byte;
            carry_q <= s_cout;
            if (last) begin
                cout_q <= s_cout;
                ovf_q  <= (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &
                          (s_byte[BYTE_W-1] != a_byte[BYTE_W-1]);
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = busy;
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
    assign bus.res_ovf   = ovf_q;

endmodule

// File: tb/tb_cska_mp_seq.sv
// Scoreboard bench for cska_mp_seq: directed corner cases, reset abort, backpressure and
// randomized traffic compared against an arithmetic reference model.
module tb_cska_mp_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;
    localparam int unsigned N_RAND = 8000;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rand_ready = 1'b0;

    cska_mp_seq_if #(.NB(NB)) bus ();

    cska_mp_seq #(.NB(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    longint acc_cyc = 0;
    res_t   exp_q[$];
    res_t   last_res = '0;
    res_t   prev_res = '0;
    logic   ov_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference: plain wide unsigned and signed arithmetic.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        logic [63:0] tot;
        longint sa, sb, d;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            r.sum  = a - b;
            r.cout = (a >= b);
            d      = sa - sb;
        end else begin
            tot    = 64'(a) + 64'(b) + 64'(cin);
            r.sum  = tot[W-1:0];
            r.cout = tot[W];
            d      = sa + sb + longint'(cin);
        end
        r.ovf = (d > 64'sd2147483647) || (d < -64'sd2147483648);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        for (int k = 0; k < int'(NB); k++) begin
            case ($urandom_range(0, 5))
                0:       w[k*8 +: 8] = 8'h00;
                1:       w[k*8 +: 8] = 8'hFF;
                2:       w[k*8 +: 8] = 8'h80;
                3:       w[k*8 +: 8] = 8'h7F;
                default: w[k*8 +: 8] = 8'($urandom);
            endcase
        end
        return w;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: samples at the falling edge, where inputs and outputs are both settled.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            ov_prev = 1'b0;
            check("reset_outputs",
                  {bus.in_ready, bus.out_valid, bus.busy, bus.res_sum, bus.res_cout, bus.res_ovf},
                  {1'b1, 1'b0, 1'b0, {W{1'b0}}, 1'b0, 1'b0});
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                check("accept_with_op_in_flight", 64'(exp_q.size()), 64'd0);
                exp_q.push_back(model(bus.op_a, bus.op_b, bus.op_cin, bus.op_sub));
                acc_cyc = cyc + 1;
            end
            if (bus.out_valid) begin
                res_t cur;
                cur = {bus.res_sum, bus.res_cout, bus.res_ovf};
                check("ready_busy_in_done", {bus.in_ready, bus.busy}, 2'b01);
                if (!ov_prev) check("latency", 64'(cyc - acc_cyc), 64'(NB));
                else          check("done_stable", cur, prev_res);
                prev_res = cur;
                if (bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        flag("unexpected_result");
                    end else begin
                        check("result", cur, exp_q.pop_front());
                        last_res = cur;
                    end
                end
            end
            ov_prev = bus.out_valid;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub);
        bit ok;
        ok = 1'b0;
        bus.op_a = a;
        bus.op_b = b;
        bus.op_cin = cin;
        bus.op_sub = sub;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("send_timeout");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.op_a = rand_word();
        bus.op_b = rand_word();
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) flag("drain_timeout");
        #1;
    endtask

    task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input res_t want);
        send(a, b, cin, sub);
        drain();
        check(name, last_res, want);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        bit seen;
        logic [63:0] bc;
        bus.in_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.op_cin = 1'b0;
        bus.op_sub = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_one("wrap_add",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h00000000, 1'b1, 1'b0});
        run_one("ovf_add",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {32'h80000000, 1'b0, 1'b1});
        run_one("borrow_sub", 32'h00000005, 32'h00000007, 1'b0, 1'b1, {32'hFFFFFFFE, 1'b0, 1'b0});
        run_one("ovf_sub",    32'h80000000, 32'h00000001, 1'b0, 1'b1, {32'h7FFFFFFF, 1'b1, 1'b1});

        // Carry out of each byte position into the next.
        for (int k = 0; k < int'(NB); k++) begin
            bc = 64'h100 << (8 * k);
            run_one("byte_carry", 32'hFF << (8 * k), 32'h1 << (8 * k), 1'b0, 1'b0,
                    {bc[W-1:0], bc[W], 1'b0});
        end

        // Backpressure with a second command held valid the whole time.
        bus.out_ready = 1'b0;
        send(32'h00000010, 32'h00000020, 1'b0, 1'b0);
        bus.op_a = 32'h00000100;
        bus.op_b = 32'h00000001;
        bus.op_cin = 1'b0;
        bus.op_sub = 1'b1;
        bus.in_valid = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag("bp_out_valid_timeout");
        repeat (10) @(negedge clk);
        check("bp_held", {bus.out_valid, bus.in_ready, bus.res_sum},
              {1'b1, 1'b0, 32'h00000030});
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) flag("bp_second_accept_timeout");
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();
        check("bp_second_op", last_res, {32'h000000FF, 1'b1, 1'b0});

        // Reset two cycles into an operation: it must vanish without a result.
        send(32'hDEADBEEF, 32'h01234567, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("reset_immediate", {bus.in_ready, bus.out_valid, bus.busy, bus.res_sum},
              {1'b1, 1'b0, 1'b0, {W{1'b0}}});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        run_one("after_reset", 32'h12345678, 32'h11111111, 1'b1, 1'b0, {32'h2345678A, 1'b0, 1'b0});

        rand_ready = 1'b1;
        for (int n = 0; n < int'(N_RAND); n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(rand_word(), rand_word(), 1'($urandom), 1'($urandom));
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
